// File: rtl/header_stripper.sv
// header_stripper: splits framed stream into payload/metadata AXI-Stream ports and checks trailer counter sequence
module header_stripper #(
    parameter int DW         = 128,
    parameter int DATA_BEATS = 129,
    parameter int META_BEATS = 2,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DW-1:0]    axis_in_tdata,
    input  logic             axis_in_tvalid,
    output logic             axis_in_tready,
    output logic [DW-1:0]    axis_data_tdata,
    output logic             axis_data_tvalid,
    input  logic             axis_data_tready,
    output logic             axis_data_tlast,
    output logic [DW-1:0]    axis_meta_tdata,
    output logic             axis_meta_tvalid,
    input  logic             axis_meta_tready,
    output logic             axis_meta_tlast,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             pkt_cnt_valid,
    output logic             seq_err,
    output logic [15:0]      err_count,
    output logic [31:0]      frame_count,
    output logic [1:0]       fsm_state
);
    localparam int MAXB = DATA_BEATS > META_BEATS ? DATA_BEATS : META_BEATS;
    localparam int BW = $clog2(MAXB) + 1;
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BEATS - 1);
    localparam logic [BW-1:0] M_LAST = BW'(META_BEATS - 1);

    typedef enum logic [1:0] {S_DATA = 2'd0, S_META = 2'd1, S_TRAIL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic              pkt_cnt_valid_q, pkt_cnt_valid_d;
    logic              seq_err_q, seq_err_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [31:0]       frame_count_q, frame_count_d;
    logic              base_q, base_d;
    logic              in_data, in_meta, xfer, mismatch;
    logic [CNT_W-1:0]  trl;

    always_comb begin
        in_data          = state_q == S_DATA;
        in_meta          = state_q == S_META;
        axis_in_tready   = in_data ? axis_data_tready : (in_meta ? axis_meta_tready : 1'b1);
        axis_data_tvalid = in_data & axis_in_tvalid;
        axis_data_tdata  = in_data ? axis_in_tdata : '0;
        axis_data_tlast  = in_data && beat_cnt_q == D_LAST;
        axis_meta_tvalid = in_meta & axis_in_tvalid;
        axis_meta_tdata  = in_meta ? axis_in_tdata : '0;
        axis_meta_tlast  = in_meta && beat_cnt_q == M_LAST;
        xfer             = axis_in_tvalid & axis_in_tready;
        trl              = axis_in_tdata[CNT_W-1:0];
        // the first trailer after reset only establishes the baseline
        mismatch         = base_q && (trl != pkt_cnt_q + CNT_W'(1));
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        pkt_cnt_d        = pkt_cnt_q;
        pkt_cnt_valid_d  = 1'b0;
        seq_err_d        = 1'b0;
        err_count_d      = err_count_q;
        frame_count_d    = frame_count_q;
        base_d           = base_q;
        if (xfer) begin
            if (in_data) begin
                beat_cnt_d = beat_cnt_q == D_LAST ? '0 : beat_cnt_q + BW'(1);
                state_d    = beat_cnt_q == D_LAST ? S_META : S_DATA;
            end else if (in_meta) begin
                beat_cnt_d = beat_cnt_q == M_LAST ? '0 : beat_cnt_q + BW'(1);
                state_d    = beat_cnt_q == M_LAST ? S_TRAIL : S_META;
            end else begin
                state_d         = S_DATA;
                beat_cnt_d      = '0;
                pkt_cnt_d       = trl;
                pkt_cnt_valid_d = 1'b1;
                seq_err_d       = mismatch;
                err_count_d     = (mismatch && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
                frame_count_d   = frame_count_q + 32'd1;
                base_d          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_DATA;
            beat_cnt_q      <= '0;
            pkt_cnt_q       <= '0;
            pkt_cnt_valid_q <= 1'b0;
            seq_err_q       <= 1'b0;
            err_count_q     <= '0;
            frame_count_q   <= '0;
            base_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            pkt_cnt_q       <= pkt_cnt_d;
            pkt_cnt_valid_q <= pkt_cnt_valid_d;
            seq_err_q       <= seq_err_d;
            err_count_q     <= err_count_d;
            frame_count_q   <= frame_count_d;
            base_q          <= base_d;
        end
    end

    assign pkt_cnt       = pkt_cnt_q;
    assign pkt_cnt_valid = pkt_cnt_valid_q;
    assign seq_err       = seq_err_q;
    assign err_count     = err_count_q;
    assign frame_count   = frame_count_q;
    assign fsm_state     = state_q;
endmodule
